// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 5-stage pipeline:
//   - default datapath / register-address widths
//   - ALU opcode encodings (ALU_ADD .. ALU_SLL)
//   - operand forward-select enum used by ex_fwd_mux
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int XLEN_DEFAULT   = 32;
    localparam int REG_AW_DEFAULT = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b1001;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/ex_fwd_mux.sv
// ---------------------------------------------------------------------------
// ex_fwd_mux
// Combinational operand selector for one EX source register. Picks the
// youngest in-flight producer of rs: EX/MEM first, then MEM/WB, otherwise
// the register-file data latched in ID/EX. x0 is never forwarded.
// Ports:
//   rs_addr_i              registered source register number
//   rf_data_i              registered register-file read data
//   exmem_rd_i/we_i/res_i  EX/MEM destination, write enable, result
//   memwb_rd_i/we_i/res_i  MEM/WB destination, write enable, result
//   data_o                 selected operand value
// ---------------------------------------------------------------------------
module ex_fwd_mux
    import cpu_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic [REG_AW-1:0] rs_addr_i,
    input  logic [XLEN-1:0]   rf_data_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              exmem_we_i,
    input  logic [XLEN-1:0]   exmem_res_i,
    input  logic [REG_AW-1:0] memwb_rd_i,
    input  logic              memwb_we_i,
    input  logic [XLEN-1:0]   memwb_res_i,
    output logic [XLEN-1:0]   data_o
);

    fwd_sel_t sel;

    always_comb begin
        sel = FWD_RF;
        if (exmem_we_i && (exmem_rd_i != '0) && (exmem_rd_i == rs_addr_i)) begin
            sel = FWD_EXMEM;
        end else if (memwb_we_i && (memwb_rd_i != '0) && (memwb_rd_i == rs_addr_i)) begin
            sel = FWD_MEMWB;
        end
    end

    always_comb begin
        data_o = rf_data_i;
        case (sel)
            FWD_EXMEM: data_o = exmem_res_i;
            FWD_MEMWB: data_o = memwb_res_i;
            default:   data_o = rf_data_i;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register plus EX operand preparation. Latches the decoded
// instruction, forwards EX/MEM and MEM/WB results into the ALU operands,
// inserts one bubble on a load-use hazard, and honours mem_stall (hold) and
// flush (bubble).
// Optional feature macro: ID_EX_BUBBLE_CNT_EN adds parameter CNT_W and a
// saturating bubble_cnt output counting flush / load-use bubbles.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   id_*                       decoded instruction from ID
//   exmem_*, memwb_*           forwarding sources
//   mem_stall, flush           downstream hold, taken-branch kill
//   id_stall                   freeze PC/IF/ID this cycle
//   ex_valid, ex_pc            registered valid and PC
//   alu_op1, alu_op2, alu_ctrl ALU inputs
//   ex_store_data              forwarded rs2 for stores
//   ex_rd, ex_reg_we,
//   ex_mem_rd, ex_mem_wr       control to EX/MEM, zero when !ex_valid
// ---------------------------------------------------------------------------
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int REG_AW = REG_AW_DEFAULT
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_rs1_data,
    input  logic [XLEN-1:0]   id_rs2_data,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [3:0]        id_alu_ctrl,
    input  logic              id_src2_imm,
    input  logic              id_reg_we,
    input  logic              id_mem_rd,
    input  logic              id_mem_wr,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_we,
    input  logic [XLEN-1:0]   exmem_res,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_we,
    input  logic [XLEN-1:0]   memwb_res,
    input  logic              mem_stall,
    input  logic              flush,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   alu_op1,
    output logic [XLEN-1:0]   alu_op2,
    output logic [3:0]        alu_ctrl,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_we,
    output logic              ex_mem_rd,
`ifdef ID_EX_BUBBLE_CNT_EN
    output logic [CNT_W-1:0]  bubble_cnt,
`endif
    output logic              ex_mem_wr
);

    logic              valid_q,    valid_d;
    logic [XLEN-1:0]   pc_q,       pc_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]   imm_q,      imm_d;
    logic [REG_AW-1:0] rs1_addr_q, rs1_addr_d;
    logic [REG_AW-1:0] rs2_addr_q, rs2_addr_d;
    logic [REG_AW-1:0] rd_q,       rd_d;
    logic [3:0]        alu_ctrl_q, alu_ctrl_d;
    logic              src2_imm_q, src2_imm_d;
    logic              reg_we_q,   reg_we_d;
    logic              mem_rd_q,   mem_rd_d;
    logic              mem_wr_q,   mem_wr_d;

    logic              load_use;
    logic              load_bubble;
    logic [XLEN-1:0]   fwd_rs1;
    logic [XLEN-1:0]   fwd_rs2;

    assign load_use = valid_q & mem_rd_q & (rd_q != '0) & id_valid &
                      ((rd_q == id_rs1_addr) | (rd_q == id_rs2_addr));

    // A flushed instruction is discarded anyway, so a hazard on it needs no stall.
    assign id_stall    = mem_stall | (load_use & ~flush);
    assign load_bubble = ~mem_stall & (flush | load_use);

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_d       = rd_q;
        alu_ctrl_d = alu_ctrl_q;
        src2_imm_d = src2_imm_q;
        reg_we_d   = reg_we_q;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;
        if (!mem_stall) begin
            if (flush || load_use) begin
                valid_d    = 1'b0;
                pc_d       = '0;
                rs1_data_d = '0;
                rs2_data_d = '0;
                imm_d      = '0;
                rs1_addr_d = '0;
                rs2_addr_d = '0;
                rd_d       = '0;
                alu_ctrl_d = ALU_ADD;
                src2_imm_d = 1'b0;
                reg_we_d   = 1'b0;
                mem_rd_d   = 1'b0;
                mem_wr_d   = 1'b0;
            end else begin
                valid_d    = id_valid;
                pc_d       = id_pc;
                rs1_data_d = id_rs1_data;
                rs2_data_d = id_rs2_data;
                imm_d      = id_imm;
                rs1_addr_d = id_rs1_addr;
                rs2_addr_d = id_rs2_addr;
                rd_d       = id_rd_addr;
                alu_ctrl_d = id_alu_ctrl;
                src2_imm_d = id_src2_imm;
                reg_we_d   = id_reg_we;
                mem_rd_d   = id_mem_rd;
                mem_wr_d   = id_mem_wr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_q       <= '0;
            alu_ctrl_q <= ALU_ADD;
            src2_imm_q <= 1'b0;
            reg_we_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_q       <= rd_d;
            alu_ctrl_q <= alu_ctrl_d;
            src2_imm_q <= src2_imm_d;
            reg_we_q   <= reg_we_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
        end
    end

    ex_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs1 (
        .rs_addr_i   (rs1_addr_q),
        .rf_data_i   (rs1_data_q),
        .exmem_rd_i  (exmem_rd),
        .exmem_we_i  (exmem_we),
        .exmem_res_i (exmem_res),
        .memwb_rd_i  (memwb_rd),
        .memwb_we_i  (memwb_we),
        .memwb_res_i (memwb_res),
        .data_o      (fwd_rs1)
    );

    ex_fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_rs2 (
        .rs_addr_i   (rs2_addr_q),
        .rf_data_i   (rs2_data_q),
        .exmem_rd_i  (exmem_rd),
        .exmem_we_i  (exmem_we),
        .exmem_res_i (exmem_res),
        .memwb_rd_i  (memwb_rd),
        .memwb_we_i  (memwb_we),
        .memwb_res_i (memwb_res),
        .data_o      (fwd_rs2)
    );

    assign ex_valid      = valid_q;
    assign ex_pc         = pc_q;
    assign alu_op1       = fwd_rs1;
    assign alu_op2       = src2_imm_q ? imm_q : fwd_rs2;
    assign alu_ctrl      = alu_ctrl_q;
    assign ex_store_data = fwd_rs2;
    assign ex_rd         = rd_q;
    // id_valid=0 loads may carry stale decode bits; never let them reach EX/MEM.
    assign ex_reg_we     = valid_q & reg_we_q;
    assign ex_mem_rd     = valid_q & mem_rd_q;
    assign ex_mem_wr     = valid_q & mem_wr_q;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [CNT_W-1:0] bubble_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
        end else if (load_bubble && (bubble_cnt_q != '1)) begin
            bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`else
    logic unused_load_bubble;
    assign unused_load_bubble = load_bubble;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [3:0]  id_alu_ctrl;
    logic        id_src2_imm, id_reg_we, id_mem_rd, id_mem_wr;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_we, memwb_we;
    logic [31:0] exmem_res, memwb_res;
    logic        mem_stall, flush;
    logic        id_stall, ex_valid;
    logic [31:0] ex_pc, alu_op1, alu_op2, ex_store_data;
    logic [3:0]  alu_ctrl;
    logic [4:0]  ex_rd;
    logic        ex_reg_we, ex_mem_rd, ex_mem_wr;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [15:0] bubble_cnt;
    int          exp_cnt;
`endif

    int checks;
    int errors;

    id_ex_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_rs1_data   (id_rs1_data),
        .id_rs2_data   (id_rs2_data),
        .id_imm        (id_imm),
        .id_rs1_addr   (id_rs1_addr),
        .id_rs2_addr   (id_rs2_addr),
        .id_rd_addr    (id_rd_addr),
        .id_alu_ctrl   (id_alu_ctrl),
        .id_src2_imm   (id_src2_imm),
        .id_reg_we     (id_reg_we),
        .id_mem_rd     (id_mem_rd),
        .id_mem_wr     (id_mem_wr),
        .exmem_rd      (exmem_rd),
        .exmem_we      (exmem_we),
        .exmem_res     (exmem_res),
        .memwb_rd      (memwb_rd),
        .memwb_we      (memwb_we),
        .memwb_res     (memwb_res),
        .mem_stall     (mem_stall),
        .flush         (flush),
        .id_stall      (id_stall),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_ctrl      (alu_ctrl),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_reg_we     (ex_reg_we),
        .ex_mem_rd     (ex_mem_rd),
`ifdef ID_EX_BUBBLE_CNT_EN
        .bubble_cnt    (bubble_cnt),
`endif
        .ex_mem_wr     (ex_mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  rs1a, rs2a, rd;
        logic [31:0] pc, rs1d, rs2d, imm;
        logic [3:0]  ctrl;
        logic        s2i;
        logic [2:0]  ctl;       // {reg_we, mem_rd, mem_wr}
        logic [4:0]  xrd;
        logic        xwe;
        logic [31:0] xres;
        logic [4:0]  wrd;
        logic        wwe;
        logic [31:0] wres;
        logic        stall, flush;
        logic        e_stall, e_v;
        logic [2:0]  e_ctl;
        logic        chk;       // operands/pc/rd/ctrl meaningful
        logic [31:0] e_pc, e_op1, e_op2, e_sd;
        logic [4:0]  e_rd;
        logic [3:0]  e_ctrl;
    } vec_t;

    localparam int NV = 23;
    vec_t vt[NV];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        id_valid    = t.v;
        id_rs1_addr = t.rs1a;
        id_rs2_addr = t.rs2a;
        id_rd_addr  = t.rd;
        id_pc       = t.pc;
        id_rs1_data = t.rs1d;
        id_rs2_data = t.rs2d;
        id_imm      = t.imm;
        id_alu_ctrl = t.ctrl;
        id_src2_imm = t.s2i;
        {id_reg_we, id_mem_rd, id_mem_wr} = t.ctl;
        exmem_rd    = t.xrd;
        exmem_we    = t.xwe;
        exmem_res   = t.xres;
        memwb_rd    = t.wrd;
        memwb_we    = t.wwe;
        memwb_res   = t.wres;
        mem_stall   = t.stall;
        flush       = t.flush;
    endtask

    initial begin
        checks = 0;
        errors = 0;
`ifdef ID_EX_BUBBLE_CNT_EN
        exp_cnt = 0;
`endif
        //        v    rs1a  rs2a  rd     pc          rs1d          rs2d       imm            ctrl  s2i  ctl      xrd   xwe  xres        wrd   wwe  wres          stl  fl    e_stl e_v  e_ctl   chk   e_pc        e_op1         e_op2          e_sd       e_rd  e_ctrl
        vt[0]  = '{1'b1,5'd1, 5'd2, 5'd3, 32'h100,32'h5,   32'h6, 32'h0,        4'd0,1'b0,3'b100,5'd0, 1'b0,32'h0,  5'd0, 1'b0,32'h0,   1'b0,1'b0, 1'b0,1'b1,3'b100,1'b1, 32'h100,32'h5,   32'h6,       32'h6, 5'd3, 4'd0};
        vt[1]  = '{1'b1,5'd3, 5'd4, 5'd6, 32'h104,32'h99,  32'h7, 32'h0,        4'd1,1'b0,3'b100,5'd3, 1'b1,32'h10, 5'd3, 1'b1,32'h20,  1'b0,1'b0, 1'b0,1'b1,3'b100,1'b1, 32'h104,32'h10,  32'h7,       32'h7, 5'd6, 4'd1};
        vt[2]  = '{1'b1,5'd3, 5'd4, 5'd7, 32'h108,32'h99,  32'h8, 32'h0,        4'd0,1'b0,3'b100,5'd3, 1'b0,32'h10, 5'd3, 1'b1,32'h20,  1'b0,1'b0, 1'b0,1'b1,3'b100,1'b1, 32'h108,32'h20,  32'h8,       32'h8, 5'd7, 4'd0};
        vt[3]  = '{1'b1,5'd0, 5'd0, 5'd8, 32'h10c,32'h11,  32'h22,32'h0,        4'd0,1'b0,3'b100,5'd0, 1'b1,32'h55, 5'd0, 1'b1,32'h55,  1'b0,1'b0, 1'b0,1'b1,3'b100,1'b1, 32'h10c,32'h11,  32'h22,      32'h22,5'd8, 4'd0};
        vt[4]  = '{1'b1,5'd9, 5'd10,5'd11,32'h110,32'h1,   32'h2, 32'h0,        4'd3,1'b0,3'b100,5'd9, 1'b1,32'hAA, 5'd10,1'b1,32'hBB,  1'b0,1'b0, 1'b0,1'b1,3'b100,1'b1, 32'h110,32'hAA,  32'hBB,      32'hBB,5'd11,4'd3};
        vt[5]  = '{1'b1,5'd1, 5'd12,5'd0, 32'h114,32'h3,   32'h0, 32'hFFFFFFFC, 4'd0,1'b1,3'b001,5'd12,1'b1,32'h7,  5'd0, 1'b0,32'h0,   1'b0,1'b0, 1'b0,1'b1,3'b001,1'b1, 32'h114,32'h3,   32'hFFFFFFFC,32'h7, 5'd0, 4'd0};
        vt[6]  = '{1'b1,5'd2, 5'd0, 5'd5, 32'h118,32'h40,  32'h0, 32'h4,        4'd0,1'b1,3'b110,5'd0, 1'b0,32'h0,  5'd0, 1'b0,32'h0,   1'b0,1'b0, 1'b0,1'b1,3'b110,1'b1, 32'h118,32'h40,  32'h4,       32'h0, 5'd5, 4'd0};
        vt[7]  = '{1'b1,5'd5, 5'd1, 5'd6, 32'h11c,32'h1111,32'h2, 32'h0,        4'd0,1'b0,3'b100,5'd0, 1'b0,32'h0,  5'd0, 1'b0,32'h0,   1'b0,1'b0, 1'b1,1'b0,3'b000,1'b0, 32'h0,  32'h0,   32'h0,       32'h0, 5'd0, 4'd0};
        vt[8]  = '{1'b1,5'd5, 5'd1, 5'd6, 32'h11c,32'h1111,32'h2, 32'h0,        4'd0,1'b0,3'b100,5'd0, 1'b0,32'h0,  5'd5, 1'b1,32'hABCD,1'b0,1'b0, 1'b0,1'b1,3'b100,1'b1, 32'h11c,32'hABCD,32'h2,       32'h2, 5'd6, 4'd0};
        vt[9]  = '{1'b1,5'd1, 5'd2, 5'd9, 32'h120,32'h1,   32'h2, 32'h0,        4'd0,1'b0,3'b100,5'd0, 1'b0,32'h0,  5'd0, 1'b0,32'h0,   1'b0,1'b1, 1'b0,1'b0,3'b000,1'b0, 32'h0,  32'h0,   32'h0,       32'h0, 5'd0, 4'd0};
        vt[10] = '{1'b1,5'd1, 5'd0, 5'd7, 32'h124,32'h8,   32'h0, 32'h0,        4'd0,1'b1,3'b110,5'd0, 1'b0,32'h0,  5'd0, 1'b0,32'h0,   1'b0,1'b0, 1'b0,1'b1,3'b110,1'b1, 32'h124,32'h8,   32'h0,       32'h0, 5'd7, 4'd0};
        vt[11] = '{1'b1,5'd7, 5'd0, 5'd10,32'h128,32'h0,   32'h0, 32'h0,        4'd0,1'b0,3'b100,5'd0, 1'b0,32'h0,  5'd0, 1'b0,32'h0,   1'b0,1'b1, 1'b0,1'b0,3'b000,1'b0, 32'h0,  32'h0,   32'h0,       32'h0, 5'd0, 4'd0};
        vt[12] = '{1'b1,5'd1, 5'd2, 5'd12,32'h12c,32'h31,  32'h32,32'h0,        4'd2,1'b0,3'b100,5'd0, 1'b0,32'h0,  5'd0, 1'b0,32'h0,   1'b0,1'b0, 1'b0,1'b1,3'b100,1'b1, 32'h12c,32'h31,  32'h32,      32'h32,5'd12,4'd2};
        vt[13] = '{1'b1,5'd3, 5'd4, 5'd13,32'h130,32'h77,  32'h78,32'h0,        4'd0,1'b0,3'b100,5'd0, 1'b0,32'h0,  5'd0, 1'b0,32'h0,   1'b1,1'b1, 1'b1,1'b1,3'b100,1'b1, 32'h12c,32'h31,  32'h32,      32'h32,5'd12,4'd2};
        vt[14] = vt[13];
        vt[15] = vt[13];
        vt[16] = '{1'b1,5'd3, 5'd4, 5'd13,32'h130,32'h77,  32'h78,32'h0,        4'd0,1'b0,3'b100,5'd0, 1'b0,32'h0,  5'd0, 1'b0,32'h0,   1'b0,1'b1, 1'b0,1'b0,3'b000,1'b0, 32'h0,  32'h0,   32'h0,       32'h0, 5'd0, 4'd0};
        vt[17] = '{1'b0,5'd1, 5'd2, 5'd0, 32'h134,32'h0,   32'h0, 32'h0,        4'd0,1'b0,3'b110,5'd0, 1'b0,32'h0,  5'd0, 1'b0,32'h0,   1'b0,1'b0, 1'b0,1'b0,3'b000,1'b0, 32'h0,  32'h0,   32'h0,       32'h0, 5'd0, 4'd0};
        vt[18] = '{1'b1,5'd1, 5'd0, 5'd0, 32'h138,32'h8,   32'h0, 32'h0,        4'd0,1'b1,3'b110,5'd0, 1'b0,32'h0,  5'd0, 1'b0,32'h0,   1'b0,1'b0, 1'b0,1'b1,3'b110,1'b1, 32'h138,32'h8,   32'h0,       32'h0, 5'd0, 4'd0};
        vt[19] = '{1'b1,5'd0, 5'd0, 5'd1, 32'h13c,32'h0,   32'h0, 32'h0,        4'd0,1'b0,3'b100,5'd0, 1'b0,32'h0,  5'd0, 1'b0,32'h0,   1'b0,1'b0, 1'b0,1'b1,3'b100,1'b1, 32'h13c,32'h0,   32'h0,       32'h0, 5'd1, 4'd0};
        vt[20] = '{1'b1,5'd1, 5'd0, 5'd4, 32'h140,32'h8,   32'h0, 32'h0,        4'd0,1'b1,3'b110,5'd0, 1'b0,32'h0,  5'd0, 1'b0,32'h0,   1'b0,1'b0, 1'b0,1'b1,3'b110,1'b1, 32'h140,32'h8,   32'h0,       32'h0, 5'd4, 4'd0};
        vt[21] = '{1'b1,5'd1, 5'd4, 5'd14,32'h144,32'h9,   32'h5, 32'h0,        4'd9,1'b0,3'b100,5'd0, 1'b0,32'h0,  5'd0, 1'b0,32'h0,   1'b0,1'b0, 1'b1,1'b0,3'b000,1'b0, 32'h0,  32'h0,   32'h0,       32'h0, 5'd0, 4'd0};
        vt[22] = '{1'b1,5'd1, 5'd4, 5'd14,32'h144,32'h9,   32'h5, 32'h0,        4'd9,1'b0,3'b100,5'd0, 1'b0,32'h0,  5'd4, 1'b1,32'h44,  1'b0,1'b0, 1'b0,1'b1,3'b100,1'b1, 32'h144,32'h9,   32'h44,      32'h44,5'd14,4'd9};

        // Reset state
        rst_n = 1'b0;
        apply(vt[0]);
        id_valid = 1'b0;
        #2;
        check("rst_ex_valid", 32'(ex_valid), 32'h0);
        check("rst_ctl", 32'({ex_reg_we, ex_mem_rd, ex_mem_wr}), 32'h0);
        check("rst_ops", alu_op1 | alu_op2 | ex_store_data | ex_pc, 32'h0);
        check("rst_rd_ctrl", 32'({ex_rd, alu_ctrl}), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            apply(vt[i]);
            #1;
            check($sformatf("v%0d_id_stall", i), 32'(id_stall), 32'(vt[i].e_stall));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'(vt[i].e_v));
            check($sformatf("v%0d_ctl", i), 32'({ex_reg_we, ex_mem_rd, ex_mem_wr}), 32'(vt[i].e_ctl));
            if (vt[i].chk) begin
                check($sformatf("v%0d_pc", i), ex_pc, vt[i].e_pc);
                check($sformatf("v%0d_op1", i), alu_op1, vt[i].e_op1);
                check($sformatf("v%0d_op2", i), alu_op2, vt[i].e_op2);
                check($sformatf("v%0d_store", i), ex_store_data, vt[i].e_sd);
                check($sformatf("v%0d_rd", i), 32'(ex_rd), 32'(vt[i].e_rd));
                check($sformatf("v%0d_alu_ctrl", i), 32'(alu_ctrl), 32'(vt[i].e_ctrl));
            end
`ifdef ID_EX_BUBBLE_CNT_EN
            if (!vt[i].stall && (vt[i].flush || vt[i].e_stall)) exp_cnt++;
            check($sformatf("v%0d_bubble_cnt", i), 32'(bubble_cnt), 32'(exp_cnt));
`endif
        end

        // Reset asserted mid-stall with a valid instruction in EX
        @(negedge clk);
        mem_stall = 1'b1;
        flush     = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst2_ex_valid", 32'(ex_valid), 32'h0);
        check("rst2_ctl", 32'({ex_reg_we, ex_mem_rd, ex_mem_wr}), 32'h0);
        check("rst2_ops", alu_op1 | alu_op2 | ex_store_data | ex_pc, 32'h0);
        check("rst2_rd_ctrl", 32'({ex_rd, alu_ctrl}), 32'h0);
`ifdef ID_EX_BUBBLE_CNT_EN
        check("rst2_bubble_cnt", 32'(bubble_cnt), 32'h0);
`endif
        @(negedge clk);
        rst_n     = 1'b1;
        mem_stall = 1'b0;
        memwb_we  = 1'b0;
        id_valid  = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_idle_valid", 32'(ex_valid), 32'h0);
        @(negedge clk);
        id_valid    = 1'b1;
        id_pc       = 32'h200;
        id_rs1_addr = 5'd2;
        id_rs1_data = 32'h5;
        @(posedge clk);
        #1;
        check("post_rst_load_valid", 32'(ex_valid), 32'h1);
        check("post_rst_load_pc", ex_pc, 32'h200);
        check("post_rst_load_op1", alu_op1, 32'h5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and EX operand-preparation stage of the 5-stage pipeline.
- Latches decoded instructions from ID and resolves RAW hazards by forwarding from EX/MEM and MEM/WB.
- Detects load-use hazards, inserts bubbles, and honours downstream hold and branch flush.
- Drives alu_op1/alu_op2/alu_ctrl directly into the EX-stage ALU and passes control fields to EX/MEM.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width
CNT_W, 16, width of the optional bubble counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  PC of the ID instruction
id_rs1_data, id_rs2_data  in  XLEN  register file read data
id_imm  in  XLEN  sign-extended immediate
id_rs1_addr, id_rs2_addr, id_rd_addr  in  REG_AW  source and destination register numbers
id_alu_ctrl  in  4  ALU opcode (0000 add … 1001 sll)
id_src2_imm  in  1  op2 = immediate
id_reg_we  in  1  instruction writes rd
id_mem_rd  in  1  instruction is a load
id_mem_wr  in  1  instruction is a store
exmem_rd  in  REG_AW  destination register in EX/MEM
exmem_we  in  1  EX/MEM writes rd
exmem_res  in  XLEN  EX/MEM result
memwb_rd  in  REG_AW  destination register in MEM/WB
memwb_we  in  1  MEM/WB writes rd
memwb_res  in  XLEN  MEM/WB result
mem_stall  in  1  downstream hold
flush  in  1  kill the ID instruction (taken branch)
id_stall  out  1  freeze PC/IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
ex_pc  out  XLEN  registered PC
alu_op1, alu_op2  out  XLEN  forwarded ALU operands
alu_ctrl  out  4  registered ALU opcode
ex_store_data  out  XLEN  forwarded rs2 value, used by stores
ex_rd  out  REG_AW  registered rd
ex_reg_we, ex_mem_rd, ex_mem_wr  out  1  registered control, forced to 0 when !ex_valid

Behaviour:
- Reset (async, rst_n=0): all EX registers clear to 0; ex_valid=0, alu_ctrl=0000, ex_rd=0. Outputs derived from them read 0 while reset is asserted. Reset mid-stall or mid-bubble discards everything.
- load_use = ex_valid & ex_mem_rd & ex_rd!=0 & id_valid & (ex_rd==id_rs1_addr | ex_rd==id_rs2_addr).
- id_stall = mem_stall | (load_use & !flush). Combinational.
- Register update priority per rising edge:
  1. mem_stall: hold all EX registers.
  2. flush: load a bubble (ex_valid=0, all control 0).
  3. load_use: load a bubble. ID is held by id_stall, so exactly one bubble is inserted.
  4. Otherwise: load the ID fields, with ex_valid=id_valid.
- flush arriving during mem_stall is ignored. The source holds flush until the stall releases.
- Forwarding is combinational on the registered rs1/rs2 addresses, evaluated separately for each operand:
  - EX/MEM hit if exmem_we & exmem_rd!=0 & exmem_rd==rs.
  - Otherwise MEM/WB hit if memwb_we & memwb_rd!=0 & memwb_rd==rs.
  - Otherwise use the registered register-file data.
  - Register x0 is never forwarded. EX/MEM wins when both stages hit.
- alu_op1 = forwarded rs1.
- ex_store_data = forwarded rs2.
- alu_op2 = ex_src2_imm ? registered imm : forwarded rs2.
- Latency: one cycle from ID to EX outputs. Forwarding adds no cycles.
- Bubble: ALU operands are don't-care, but ex_reg_we, ex_mem_rd, ex_mem_wr and ex_valid must be 0.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- When defined:
  - Extra output bubble_cnt [CNT_W-1:0]: increments on each edge that loads a bubble because of flush or load_use (not mem_stall holds).
  - Saturates at all-ones.
  - Clears on reset.
- When undefined: the port and counter are absent; no other behaviour changes.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU opcode localparams ALU_ADD=4'b0000 through ALU_SLL=4'b1001.
  - Forward-select enum fwd_sel_t {FWD_RF, FWD_EXMEM, FWD_MEMWB}.
  - XLEN and REG_AW defaults.
- One sub-module, ex_fwd_mux: a combinational per-operand selector, instantiated twice (rs1, rs2).

Test Plan:
- Reset: hold rst_n=0 mid-stream, then release. All outputs are 0 and ex_valid=0 until the first id_valid load.
- Forwarding:
  - add x3 in EX/MEM with exmem_res=0x10 and MEM/WB writes x3=0x20; next instruction reads x3 → alu_op1=0x10.
  - Remove the EX/MEM hit → alu_op1=0x20.
  - rd=x0 with result 0x55 → no forwarding; RF value is used.
- Load-use: lw x5 in EX (ex_mem_rd=1), ID reads x5 → id_stall=1 for exactly one cycle, then a bubble in EX. The next cycle takes x5 from memwb_res=0xABCD.
- Flush: flush=1 with id_valid=1 → next cycle ex_valid=0 and ex_reg_we=0. With ID_EX_BUBBLE_CNT_EN, bubble_cnt increments by 1.
- Hold: mem_stall=1 for 3 cycles with flush=1 → EX contents are unchanged, id_stall=1, and no bubble is counted. Release → flush is applied on the following edge.
- Immediate: id_src2_imm=1, id_imm=0xFFFFFFFC, rs2 forwarded 0x7 → alu_op2=0xFFFFFFFC and ex_store_data=0x7.
